microwave_timer_ctrl: RTL and testbench

Sequencing controller for the microwave countdown datapath, a chain of BCD digit counters for MM:SS with shared load/clear/stop controls and a combined all-zero flag. It accepts the user's start/pause/clear and door inputs, loads the keypad time into the chain, and gates the chain to decrement once per second. It drives the magnetron enable and emits the end-of-cook beep window. It sits between the front-panel logic and the timer digit chain.

---
 rtl/timer_pkg.sv | 22 ++
 rtl/microwave_timer_ctrl_if.sv | 25 ++
 rtl/tick_prescaler.sv | 40 ++++
 rtl/microwave_timer_ctrl.sv | 99 +++++++++
 tb/tb_microwave_timer_ctrl.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared encodings and defaults for the microwave cook-timer sequencer.
// State codes are also the values shown on the state_out display/debug port.
package timer_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      RUN   = 3'd2,
      PAUSE = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int TIME_W          = 16;
   localparam int DEF_TICK_DIV    = 50000000;
   localparam int DEF_BEEP_CYCLES = 100000000;

   // Bits needed to count 0..n-1, never less than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/microwave_timer_ctrl_if.sv
// Control bus between the cook sequencer (master) and the BCD MM:SS digit chain (slave).
// Strobes are plain levels sampled by the chain on each rising clk: load and clear are
// one-cycle pulses, stop=0 for one cycle means "decrement now"; all_zero is combinational.
interface microwave_timer_ctrl_if;

   logic counter_load;
   logic counter_clear;
   logic counter_stop;
   logic all_zero;

   modport master (
      output counter_load,
      output counter_clear,
      output counter_stop,
      input  all_zero
   );

   modport slave (
      input  counter_load,
      input  counter_clear,
      input  counter_stop,
      output all_zero
   );

endinterface

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
// The count freezes while disabled, so a paused partial second is kept.
module tick_prescaler
   import timer_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   input  logic i_clr,
   output logic o_tick
);

   localparam int            CW   = cnt_width(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0] PRE  = CW'(TICK_DIV - 2);

   logic [CW-1:0] r_cnt;
   logic          r_tick;

   // The tick flop is loaded one cycle early so it is high while the count sits at LAST.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else if (i_clr) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else if (i_en) begin
         r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
         r_tick <= (r_cnt == PRE);
      end else begin
         r_tick <= 1'b0;
      end
   end

   assign o_tick = r_tick;

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Cook-timer sequencer: loads the keypad time into the digit chain, gates one decrement
// per second while running, drives the magnetron and the end-of-cook beep window.
module microwave_timer_ctrl
   import timer_pkg::*;
#(
   parameter int TICK_DIV    = DEF_TICK_DIV,
   parameter int BEEP_CYCLES = DEF_BEEP_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  pause,
   input  logic                  clear_btn,
   input  logic                  door_closed,
   input  logic [TIME_W-1:0]     time_in,
   microwave_timer_ctrl_if.master chain,
   output logic                  magnetron_on,
   output logic                  beep,
   output logic [2:0]            state_out
);

   localparam int            BW        = cnt_width(BEEP_CYCLES);
   localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_CYCLES - 1);

   state_t        r_state;
   state_t        w_next;
   logic [BW-1:0] r_beep_cnt;
   logic          r_load;
   logic          r_clear;
   logic          r_beep;
   logic          w_go;
   logic          w_presc_en;
   logic          w_presc_clr;
   logic          w_tick;

   assign w_go = start & door_closed & (time_in != '0);

   always_comb begin
      w_next      = r_state;
      w_presc_en  = 1'b0;
      w_presc_clr = 1'b0;
      if (clear_btn) begin
         w_next = IDLE;
      end else begin
         case (r_state)
            IDLE:  if (w_go) w_next = LOAD;
            LOAD: begin
               w_next      = RUN;
               w_presc_clr = 1'b1;
            end
            // An empty chain ends the cook even if pause or the door want attention.
            RUN: begin
               if (chain.all_zero)            w_next = DONE;
               else if (pause | ~door_closed) w_next = PAUSE;
               else                           w_presc_en = 1'b1;
            end
            PAUSE: if (start & door_closed & ~pause) w_next = RUN;
            DONE:  if (r_beep_cnt == BEEP_LAST)      w_next = IDLE;
            default: w_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_beep_cnt <= '0;
         r_load     <= 1'b0;
         r_clear    <= 1'b0;
         r_beep     <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_load     <= (w_next == LOAD);
         r_clear    <= clear_btn;
         r_beep     <= (w_next == DONE);
         r_beep_cnt <= ((r_state == DONE) && (w_next == DONE)) ? r_beep_cnt + 1'b1 : '0;
      end
   end

   // Ticks only come from enabled RUN cycles, and RUN is left as soon as the chain is
   // empty, so the chain is never asked to decrement past 00:00.
   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_presc (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (w_presc_en),
      .i_clr  (w_presc_clr),
      .o_tick (w_tick)
   );

   assign chain.counter_load  = r_load;
   assign chain.counter_clear = r_clear;
   assign chain.counter_stop  = ~w_tick;
   assign beep                = r_beep;
   assign state_out           = r_state;
   assign magnetron_on        = (r_state == RUN) & door_closed;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Bench for microwave_timer_ctrl: BCD chain model in the loop, a behavioural reference
// checked every cycle, directed scenarios with hand-computed timing, then random traffic.
module tb_microwave_timer_ctrl;

   localparam int TICK_DIV    = 4;
   localparam int BEEP_CYCLES = 6;

   logic        clk         = 1'b0;
   logic        rst_n       = 1'b0;
   logic        start       = 1'b0;
   logic        pause       = 1'b0;
   logic        clear_btn   = 1'b0;
   logic        door_closed = 1'b1;
   logic [15:0] time_in     = 16'h0000;
   logic        magnetron_on;
   logic        beep;
   logic [2:0]  state_out;
   logic [15:0] chain_val;

   int total = 0;
   int bad   = 0;

   microwave_timer_ctrl_if bus ();

   microwave_timer_ctrl #(
      .TICK_DIV    (TICK_DIV),
      .BEEP_CYCLES (BEEP_CYCLES)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .pause        (pause),
      .clear_btn    (clear_btn),
      .door_closed  (door_closed),
      .time_in      (time_in),
      .chain        (bus),
      .magnetron_on (magnetron_on),
      .beep         (beep),
      .state_out    (state_out)
   );

   always #5 clk = ~clk;

   // ---------------- time helpers (MM:SS BCD <-> seconds) ----------------
   function automatic int bcd2sec(input logic [15:0] v);
      return (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   function automatic logic [15:0] sec2bcd(input int s);
      int m;
      int ss;
      m  = s / 60;
      ss = s % 60;
      return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   // A bare chain wraps 00:00 to 99:59; the controller must never let that happen.
   function automatic logic [15:0] bcd_dec(input logic [15:0] v);
      int s;
      s = bcd2sec(v);
      return sec2bcd((s == 0) ? (99 * 60 + 59) : (s - 1));
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  chain_val <= 16'h0000;
      else if (bus.counter_clear)  chain_val <= 16'h0000;
      else if (bus.counter_load)   chain_val <= time_in;
      else if (!bus.counter_stop)  chain_val <= bcd_dec(chain_val);
   end

   assign bus.all_zero = (chain_val == 16'h0000);

   // ---------------- behavioural reference ----------------
   // mode uses the published codes 0..4; runs counts enabled running cycles since load.
   int m_mode;
   int m_secs;
   int m_runs;
   int m_beep_left;
   bit m_tick;
   bit m_clr;

   task automatic model_reset();
      m_mode      = 0;
      m_secs      = 0;
      m_runs      = 0;
      m_beep_left = 0;
      m_tick      = 1'b0;
      m_clr       = 1'b0;
   endtask

   task automatic model_step();
      int nxt;
      bit empty;
      bit n_tick;
      empty  = (m_secs == 0);
      nxt    = m_mode;
      n_tick = 1'b0;
      if (clear_btn) nxt = 0;
      else begin
         case (m_mode)
            0: if (start && door_closed && time_in != 16'h0000) nxt = 1;
            1: begin
               nxt    = 2;
               m_runs = 0;
            end
            2: begin
               if (empty) begin
                  nxt         = 4;
                  m_beep_left = BEEP_CYCLES;
               end else if (pause || !door_closed) begin
                  nxt = 3;
               end else begin
                  m_runs = m_runs + 1;
                  n_tick = ((m_runs % TICK_DIV) == TICK_DIV - 1);
               end
            end
            3: if (start && door_closed && !pause) nxt = 2;
            4: begin
               m_beep_left = m_beep_left - 1;
               if (m_beep_left == 0) nxt = 0;
            end
            default: nxt = 0;
         endcase
      end
      if (m_clr)            m_secs = 0;
      else if (m_mode == 1) m_secs = bcd2sec(time_in);
      else if (m_tick)      m_secs = m_secs - 1;
      m_clr  = clear_btn;
      m_tick = n_tick;
      m_mode = nxt;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else        model_step();
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total = total + 1;
      if (got !== want) begin
         bad = bad + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
      end
   endtask

   function automatic int q_at(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1000;
   endfunction

   int          mon_cyc  = 0;
   int          load_q[$];
   int          tick_q[$];
   int          hist_q[$];
   int          n_beep   = 0;
   int          n_mag    = 0;
   int          run_cyc  = 0;
   int          done_cyc = 0;
   int          zero_cyc = 0;
   bit          saw_wrap = 1'b0;
   logic [15:0] prev_chain = 16'h0000;
   logic [2:0]  prev_state = 3'd0;

   always @(negedge clk) begin
      if (rst_n) begin
         chk("state",     32'(state_out),          32'(m_mode));
         chk("load",      32'(bus.counter_load),   32'(m_mode == 1));
         chk("clear",     32'(bus.counter_clear),  32'(m_clr));
         chk("stop",      32'(bus.counter_stop),   32'(!m_tick));
         chk("beep",      32'(beep),               32'(m_mode == 4));
         chk("magnetron", 32'(magnetron_on),       32'(m_mode == 2 && door_closed));
         chk("chain",     32'(chain_val),          32'(sec2bcd(m_secs)));
         mon_cyc = mon_cyc + 1;
         if (bus.counter_load)  load_q.push_back(mon_cyc);
         if (!bus.counter_stop) tick_q.push_back(mon_cyc);
         if (beep)              n_beep = n_beep + 1;
         if (magnetron_on)      n_mag = n_mag + 1;
         if (state_out == 3'd2 && prev_state != 3'd2) run_cyc = mon_cyc;
         if (state_out == 3'd4 && prev_state != 3'd4) done_cyc = mon_cyc;
         if (chain_val != prev_chain) begin
            hist_q.push_back(int'(chain_val));
            if (chain_val == 16'h0000) zero_cyc = mon_cyc;
         end
         if (chain_val == 16'h9959) saw_wrap = 1'b1;
         prev_chain = chain_val;
         prev_state = state_out;
      end
   end

   // ---------------- drivers ----------------
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   task automatic pulse_clear();
      clear_btn = 1'b1;
      cyc(1);
      clear_btn = 1'b0;
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, input string name);
      int k;
      k = 0;
      while (state_out != s && k < budget) begin
         cyc(1);
         k = k + 1;
      end
      chk(name, 32'(state_out), 32'(s));
   endtask

   function automatic logic [15:0] rand_time();
      int m;
      int s;
      m = ($urandom_range(0, 9) == 0) ? 1 : 0;
      s = $urandom_range(0, 8);
      return {4'd0, 4'(m), 4'(s / 10), 4'(s % 10)};
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish by 100000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int b_load;
      int b_tick;
      int b_hist;
      int b_beep;
      int b_mag;
      int s_cyc;
      int k;
      logic [15:0] hold_val;

      // reset values
      cyc(3);
      chk("rst_stop",  32'(bus.counter_stop),  32'd1);
      chk("rst_load",  32'(bus.counter_load),  32'd0);
      chk("rst_clear", 32'(bus.counter_clear), 32'd0);
      chk("rst_mag",   32'(magnetron_on),      32'd0);
      chk("rst_beep",  32'(beep),              32'd0);
      chk("rst_state", 32'(state_out),         32'd0);
      #2 rst_n = 1'b1;
      cyc(1);

      // 1: 00:03 full cook
      time_in = 16'h0003;
      cyc(1);
      b_load = load_q.size();
      b_tick = tick_q.size();
      b_hist = hist_q.size();
      b_beep = n_beep;
      b_mag  = n_mag;
      s_cyc  = mon_cyc + 1;
      pulse_start();
      wait_state(3'd4, 40, "s1_reach_done");
      wait_state(3'd0, 20, "s1_reach_idle");
      cyc(2);
      chk("s1_n_load",     32'(load_q.size() - b_load), 32'd1);
      chk("s1_load_lat",   32'(q_at(load_q, b_load) - s_cyc), 32'd1);
      chk("s1_first_tick", 32'(q_at(tick_q, b_tick) - q_at(load_q, b_load)), 32'd4);
      chk("s1_tick_gap",   32'(q_at(tick_q, b_tick + 1) - q_at(tick_q, b_tick)), 32'd4);
      chk("s1_n_tick",     32'(tick_q.size() - b_tick), 32'd3);
      chk("s1_hist0",      32'(q_at(hist_q, b_hist)),     32'h3);
      chk("s1_hist1",      32'(q_at(hist_q, b_hist + 1)), 32'h2);
      chk("s1_hist2",      32'(q_at(hist_q, b_hist + 2)), 32'h1);
      chk("s1_hist3",      32'(q_at(hist_q, b_hist + 3)), 32'h0);
      chk("s1_done_lat",   32'(done_cyc - zero_cyc), 32'd1);
      chk("s1_beep_len",   32'(n_beep - b_beep), 32'd6);
      chk("s1_mag_len",    32'(n_mag - b_mag), 32'd13);

      // 2: 01:00 borrows to 00:59 and stops cleanly at 00:00
      time_in = 16'h0100;
      b_tick  = tick_q.size();
      b_hist  = hist_q.size();
      pulse_start();
      wait_state(3'd4, 300, "s2_reach_done");
      wait_state(3'd0, 20, "s2_reach_idle");
      cyc(6);
      chk("s2_borrow", 32'(q_at(hist_q, b_hist + 1)), 32'h0059);
      chk("s2_hist_n", 32'(hist_q.size() - b_hist), 32'd61);
      chk("s2_n_tick", 32'(tick_q.size() - b_tick), 32'd60);
      chk("s2_nowrap", 32'(saw_wrap), 32'd0);

      // 3: door opens two cycles after a tick, partial second survives the pause
      time_in = 16'h0010;
      pulse_start();
      k = 0;
      while (bus.counter_stop && k < 20) begin
         cyc(1);
         k = k + 1;
      end
      chk("s3_tick_seen", 32'(bus.counter_stop), 32'd0);
      cyc(2);
      door_closed = 1'b0;
      #1;
      chk("s3_mag_kill", 32'(magnetron_on), 32'd0);
      chk("s3_still_run", 32'(state_out), 32'd2);
      cyc(1);
      chk("s3_paused", 32'(state_out), 32'd3);
      hold_val = chain_val;
      cyc(6);
      chk("s3_hold", 32'(chain_val), 32'(hold_val));
      door_closed = 1'b1;
      cyc(1);
      b_tick = tick_q.size();
      pulse_start();
      k = 0;
      while (tick_q.size() == b_tick && k < 10) begin
         cyc(1);
         k = k + 1;
      end
      chk("s3_resume_tick", 32'(q_at(tick_q, b_tick) - run_cyc), 32'd2);

      // 5: clear from RUN, PAUSE, DONE, and clear together with start
      pulse_clear();
      chk("s5_run_state", 32'(state_out), 32'd0);
      chk("s5_run_clr",   32'(bus.counter_clear), 32'd1);
      chk("s5_run_mag",   32'(magnetron_on), 32'd0);
      cyc(1);
      chk("s5_clr_once",  32'(bus.counter_clear), 32'd0);
      chk("s5_chain0",    32'(chain_val), 32'h0);

      time_in = 16'h0005;
      pulse_start();
      cyc(6);
      pause = 1'b1;
      cyc(2);
      chk("s5_in_pause", 32'(state_out), 32'd3);
      pause = 1'b0;
      pulse_clear();
      chk("s5_pause_state", 32'(state_out), 32'd0);
      chk("s5_pause_clr",   32'(bus.counter_clear), 32'd1);

      time_in = 16'h0001;
      pulse_start();
      wait_state(3'd4, 20, "s5_reach_done");
      cyc(2);
      chk("s5_done_beep", 32'(beep), 32'd1);
      pulse_clear();
      chk("s5_done_state", 32'(state_out), 32'd0);
      chk("s5_done_beep0", 32'(beep), 32'd0);
      chk("s5_done_clr",   32'(bus.counter_clear), 32'd1);

      time_in   = 16'h0002;
      start     = 1'b1;
      clear_btn = 1'b1;
      cyc(1);
      start     = 1'b0;
      clear_btn = 1'b0;
      chk("s5_both_load", 32'(bus.counter_load), 32'd0);
      cyc(2);
      chk("s5_both_idle", 32'(state_out), 32'd0);

      // 4: start ignored with zero time or an open door
      b_load  = load_q.size();
      time_in = 16'h0000;
      pulse_start();
      cyc(3);
      time_in     = 16'h0005;
      door_closed = 1'b0;
      pulse_start();
      cyc(3);
      door_closed = 1'b1;
      cyc(1);
      chk("s4_no_load", 32'(load_q.size() - b_load), 32'd0);
      chk("s4_idle",    32'(state_out), 32'd0);

      // 6: asynchronous reset in the middle of a run
      time_in = 16'h0002;
      pulse_start();
      cyc(5);
      chk("s6_running", 32'(state_out), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("s6_rst_stop",  32'(bus.counter_stop), 32'd1);
      chk("s6_rst_mag",   32'(magnetron_on), 32'd0);
      chk("s6_rst_state", 32'(state_out), 32'd0);
      chk("s6_rst_beep",  32'(beep), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      cyc(5);
      chk("s6_no_autorun", 32'(state_out), 32'd0);
      pulse_start();
      wait_state(3'd4, 20, "s6_reach_done");
      wait_state(3'd0, 20, "s6_reach_idle");

      // random traffic against the reference
      for (int i = 0; i < 600; i++) begin
         start     = ($urandom_range(0, 9) == 0);
         pause     = ($urandom_range(0, 29) == 0);
         clear_btn = ($urandom_range(0, 79) == 0);
         if ($urandom_range(0, 39) == 0) door_closed = ~door_closed;
         if ($urandom_range(0, 19) == 0) time_in = rand_time();
         cyc(1);
      end
      start       = 1'b0;
      pause       = 1'b0;
      clear_btn   = 1'b0;
      door_closed = 1'b1;
      cyc(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
